mem_dp_be: RTL and testbench

//  Dual-port synchronous RAM; successor to the single-port 4096x16 test memory.

---
 rtl/mem_pkg.sv | 8 +
 rtl/mem_init_seq.sv | 40 ++++
 rtl/mem_dp_be.sv | 102 ++++++++++
 tb/tb_mem_dp_be.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// mem_pkg: shared constants and FSM encoding for the dual-port byte-enable RAM
package mem_pkg;
  localparam int RDW_OLD = 0;
  localparam int RDW_NEW = 1;
  localparam int INIT_ADDR = 0;
  localparam int INIT_ZERO = 1;
  typedef enum logic {ST_INIT = 1'b0, ST_READY = 1'b1} state_e;
endpackage

// File: rtl/mem_init_seq.sv
// mem_init_seq: post-reset fill sequencer, one word per cycle from address 0
module mem_init_seq
  import mem_pkg::*;
#(
  parameter int DWIDTH = 16,
  parameter int AWIDTH = 12,
  parameter int WORDS = 4096,
  parameter int INIT_MODE = 0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              busy,
  output logic              init_we,
  output logic [AWIDTH-1:0] init_addr,
  output logic [DWIDTH-1:0] init_d
);
  state_e state_q, state_d;
  logic [AWIDTH-1:0] cnt_q, cnt_d;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_INIT;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
    end
  end
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    if (state_q == ST_INIT) begin
      cnt_d = cnt_q + 1'b1;
      state_d = (cnt_q == AWIDTH'(WORDS - 1)) ? ST_READY : ST_INIT;
    end
  end
  assign busy = (state_q == ST_INIT);
  assign init_we = busy;
  assign init_addr = cnt_q;
  assign init_d = (INIT_MODE == INIT_ZERO) ? '0 : DWIDTH'(cnt_q);
endmodule

// File: rtl/mem_dp_be.sv
// mem_dp_be: dual-port RAM, port A r/w with byte enables, port B read-only, hardware init fill
module mem_dp_be
  import mem_pkg::*;
#(
  parameter int DWIDTH = 16,
  parameter int AWIDTH = 12,
  parameter int WORDS = 4096,
  parameter int RDW_MODE = 0,
  parameter int OUT_REG = 0,
  parameter int INIT_MODE = 0
) (
  input  logic                clk,
  input  logic                rst,
  output logic                busy,
  input  logic                a_en,
  input  logic                a_we,
  input  logic [DWIDTH/8-1:0] a_be,
  input  logic [AWIDTH-1:0]   a_addr,
  input  logic [DWIDTH-1:0]   a_d,
  output logic [DWIDTH-1:0]   a_q,
  output logic                a_qv,
  input  logic                b_en,
  input  logic [AWIDTH-1:0]   b_addr,
  output logic [DWIDTH-1:0]   b_q,
  output logic                b_qv
);
  localparam int NB = DWIDTH / 8;
  if (DWIDTH % 8 != 0 || WORDS > 2 ** AWIDTH) begin : g_bad_param
    $error("mem_dp_be: DWIDTH must be a multiple of 8 and WORDS <= 2**AWIDTH");
  end
  logic [DWIDTH-1:0] mem [WORDS];
  logic init_we;
  logic [AWIDTH-1:0] init_addr;
  logic [DWIDTH-1:0] init_d;
  logic a_in, b_in, a_req, b_req, a_wr;
  logic [DWIDTH-1:0] a_cur, b_cur, a_mrg, a_rd_d, b_rd_d;
  logic a_v1_q, b_v1_q;
  logic [DWIDTH-1:0] a_d1_q, b_d1_q;
  mem_init_seq #(
    .DWIDTH(DWIDTH), .AWIDTH(AWIDTH), .WORDS(WORDS), .INIT_MODE(INIT_MODE)
  ) u_init (
    .clk(clk), .rst(rst), .busy(busy),
    .init_we(init_we), .init_addr(init_addr), .init_d(init_d)
  );
  always_comb begin
    a_in = int'(a_addr) < WORDS;
    b_in = int'(b_addr) < WORDS;
    a_req = ~busy & a_en;
    b_req = ~busy & b_en;
    a_wr = a_req & a_we & a_in;
    a_cur = a_in ? mem[a_addr] : '0;
    b_cur = b_in ? mem[b_addr] : '0;
    a_mrg = a_cur;
    for (int k = 0; k < NB; k++) a_mrg[8*k+:8] = a_be[k] ? a_d[8*k+:8] : a_cur[8*k+:8];
    // new-data mode forwards the merged word to both ports when they collide
    a_rd_d = (RDW_MODE == RDW_NEW && a_wr) ? a_mrg : a_cur;
    b_rd_d = (RDW_MODE == RDW_NEW && a_wr && a_addr == b_addr) ? a_mrg : b_cur;
  end
  always_ff @(posedge clk) begin
    if (a_wr) mem[a_addr] <= a_mrg;
    else if (init_we) mem[init_addr] <= init_d;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_v1_q <= 1'b0;
      b_v1_q <= 1'b0;
      a_d1_q <= '0;
      b_d1_q <= '0;
    end else begin
      a_v1_q <= a_req;
      b_v1_q <= b_req;
      if (a_req) a_d1_q <= a_rd_d;
      if (b_req) b_d1_q <= b_rd_d;
    end
  end
  if (OUT_REG != 0) begin : g_oreg
    logic a_v2_q, b_v2_q;
    logic [DWIDTH-1:0] a_d2_q, b_d2_q;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        a_v2_q <= 1'b0;
        b_v2_q <= 1'b0;
        a_d2_q <= '0;
        b_d2_q <= '0;
      end else begin
        a_v2_q <= a_v1_q;
        b_v2_q <= b_v1_q;
        if (a_v1_q) a_d2_q <= a_d1_q;
        if (b_v1_q) b_d2_q <= b_d1_q;
      end
    end
    assign a_q = a_d2_q;
    assign a_qv = a_v2_q;
    assign b_q = b_d2_q;
    assign b_qv = b_v2_q;
  end else begin : g_noreg
    assign a_q = a_d1_q;
    assign a_qv = a_v1_q;
    assign b_q = b_d1_q;
    assign b_qv = b_v1_q;
  end
endmodule

// File: tb/tb_mem_dp_be.sv
// tb_mem_dp_be: two shared-stimulus instances (default, and 3000-word new-data registered) vs a word-level model
module tb_mem_dp_be;
  logic clk = 1'b0, rst = 1'b1;
  logic a_en = 1'b0, a_we = 1'b0, b_en = 1'b0;
  logic [1:0] a_be = '0;
  logic [11:0] a_addr = '0, b_addr = '0;
  logic [15:0] a_d = '0;
  logic [1:0] busy_w, aqv_w, bqv_w;
  logic [15:0] aq_w[2], bq_w[2];
  int n_pass = 0, n_tot = 0;
  bit run = 1'b0;
  always #5 clk = ~clk;
  mem_dp_be u_d0 (
    .clk(clk), .rst(rst), .busy(busy_w[0]), .a_en(a_en), .a_we(a_we), .a_be(a_be),
    .a_addr(a_addr), .a_d(a_d), .a_q(aq_w[0]), .a_qv(aqv_w[0]),
    .b_en(b_en), .b_addr(b_addr), .b_q(bq_w[0]), .b_qv(bqv_w[0])
  );
  mem_dp_be #(.WORDS(3000), .RDW_MODE(1), .OUT_REG(1)) u_d1 (
    .clk(clk), .rst(rst), .busy(busy_w[1]), .a_en(a_en), .a_we(a_we), .a_be(a_be),
    .a_addr(a_addr), .a_d(a_d), .a_q(aq_w[1]), .a_qv(aqv_w[1]),
    .b_en(b_en), .b_addr(b_addr), .b_q(bq_w[1]), .b_qv(bqv_w[1])
  );
  localparam int WDS[2] = '{4096, 3000};
  localparam int LAT[2] = '{1, 2};
  localparam int RDW[2] = '{0, 1};
  logic [15:0] m[2][4096];
  int cyc[2];
  int t = 0;
  logic rv[2][2][4];
  logic [15:0] rd[2][2][4];
  logic ebusy[2], eav[2], ebv[2];
  logic [15:0] eaq[2], ebq[2];
  // word-level model: init fill counts edges, reads are delayed by the instance latency
  always @(posedge clk or posedge rst) begin
    logic [15:0] ao, bo, mg;
    logic wr;
    int s;
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        cyc[i] = 0; ebusy[i] = 1'b1; eav[i] = 1'b0; ebv[i] = 1'b0; eaq[i] = '0; ebq[i] = '0;
        for (int p = 0; p < 2; p++) for (int j = 0; j < 4; j++) rv[i][p][j] = 1'b0;
      end
    end else begin
      t++;
      for (int i = 0; i < 2; i++) begin
        if (cyc[i] < WDS[i]) begin
          m[i][cyc[i]] = 16'(cyc[i]);
          cyc[i]++;
          rv[i][0][t & 3] = 1'b0;
          rv[i][1][t & 3] = 1'b0;
        end else begin
          ao = (int'(a_addr) < WDS[i]) ? m[i][a_addr] : 16'h0;
          bo = (int'(b_addr) < WDS[i]) ? m[i][b_addr] : 16'h0;
          mg = {a_be[1] ? a_d[15:8] : ao[15:8], a_be[0] ? a_d[7:0] : ao[7:0]};
          wr = a_en && a_we && int'(a_addr) < WDS[i];
          if (RDW[i] == 1 && wr) begin
            ao = mg;
            if (b_addr == a_addr) bo = mg;
          end
          if (wr) m[i][a_addr] = mg;
          rv[i][0][t & 3] = a_en; rd[i][0][t & 3] = ao;
          rv[i][1][t & 3] = b_en; rd[i][1][t & 3] = bo;
        end
        ebusy[i] = cyc[i] < WDS[i];
        s = (t - (LAT[i] - 1)) & 3;
        eav[i] = rv[i][0][s];
        if (eav[i]) eaq[i] = rd[i][0][s];
        ebv[i] = rv[i][1][s];
        if (ebv[i]) ebq[i] = rd[i][1][s];
      end
    end
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    else n_pass++;
  endtask
  always @(negedge clk) begin
    if (run) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("d%0d_busy", i), 32'(busy_w[i]), 32'(ebusy[i]));
        chk($sformatf("d%0d_a_qv", i), 32'(aqv_w[i]), 32'(eav[i]));
        chk($sformatf("d%0d_b_qv", i), 32'(bqv_w[i]), 32'(ebv[i]));
        chk($sformatf("d%0d_a_q", i), 32'(aq_w[i]), 32'(eaq[i]));
        chk($sformatf("d%0d_b_q", i), 32'(bq_w[i]), 32'(ebq[i]));
      end
    end
  end
  function automatic logic [11:0] raddr(input bit low);
    return low ? 12'($urandom_range(0, 31)) :
           (($urandom % 4 == 0) ? 12'($urandom_range(2990, 4095)) : 12'($urandom_range(0, 4095)));
  endfunction
  task automatic rnd(input bit high_only);
    a_en = 1'($urandom); a_we = 1'($urandom); a_be = 2'($urandom); a_d = 16'($urandom);
    b_en = 1'($urandom);
    a_addr = high_only ? 12'($urandom_range(1024, 4095)) : raddr(($urandom % 2) == 1);
    b_addr = ($urandom % 2 == 1) ? a_addr : (high_only ? 12'($urandom_range(1024, 4095)) : raddr(1'b0));
  endtask
  task automatic req(input logic ae, input logic aw, input logic [1:0] be, input logic [11:0] aa,
                     input logic [15:0] ad, input logic ben, input logic [11:0] ba);
    @(negedge clk);
    a_en = ae; a_we = aw; a_be = be; a_addr = aa; a_d = ad; b_en = ben; b_addr = ba;
  endtask
  task automatic idle();
    @(negedge clk);
    a_en = 1'b0; b_en = 1'b0;
  endtask
  task automatic count_init(input string nm);
    int c0 = 0, c1 = 0;
    for (int k = 0; k < 5000; k++) begin
      c0 += int'(busy_w[0]); c1 += int'(busy_w[1]);
      if (!busy_w[0]) break;
      rnd(1'b1);
      @(negedge clk);
    end
    a_en = 1'b0; b_en = 1'b0;
    chk({nm, "_busy_cycles_d0"}, 32'(c0), 32'd4096);
    chk({nm, "_busy_cycles_d1"}, 32'(c1), 32'd3000);
  endtask
  task automatic pulse_rst(input string nm);
    @(posedge clk);
    #2 rst = 1'b1; a_en = 1'b0; b_en = 1'b0;
    @(negedge clk);
    chk({nm, "_busy0"}, 32'(busy_w[0]), 32'd1);
    chk({nm, "_busy1"}, 32'(busy_w[1]), 32'd1);
    chk({nm, "_qv0"}, {30'd0, aqv_w[0], bqv_w[0]}, 32'd0);
    chk({nm, "_qv1"}, {30'd0, aqv_w[1], bqv_w[1]}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask
  initial begin
    repeat (3) @(negedge clk);
    chk("reset_a_q0", 32'(aq_w[0]), 32'd0);
    chk("reset_busy0", 32'(busy_w[0]), 32'd1);
    run = 1'b1;
    rst = 1'b0;
    count_init("fill");
    req(0, 0, 2'b00, 12'h000, 16'h0, 1, 12'h123);
    idle(); chk("rd123_d0", 32'(bq_w[0]), 32'h0123); chk("rd123_qv0", 32'(bqv_w[0]), 32'd1);
    idle(); chk("rd123_d1", 32'(bq_w[1]), 32'h0123);
    req(1, 1, 2'b01, 12'h010, 16'hBEEF, 0, 12'h0);
    req(1, 0, 2'b00, 12'h010, 16'h0, 0, 12'h0);
    idle(); chk("be01_d0", 32'(aq_w[0]), 32'h00EF);
    idle(); chk("be01_d1", 32'(aq_w[1]), 32'h00EF);
    req(1, 1, 2'b10, 12'h010, 16'hBEEF, 0, 12'h0);
    req(1, 0, 2'b00, 12'h010, 16'h0, 0, 12'h0);
    idle(); chk("be10_d0", 32'(aq_w[0]), 32'hBEEF);
    idle(); chk("be10_d1", 32'(aq_w[1]), 32'hBEEF);
    req(1, 1, 2'b11, 12'h020, 16'h5555, 1, 12'h020);
    idle(); chk("rdw_old_b", 32'(bq_w[0]), 32'h0020); chk("rdw_old_a", 32'(aq_w[0]), 32'h0020);
    idle(); chk("rdw_new_b", 32'(bq_w[1]), 32'h5555); chk("rdw_new_a", 32'(aq_w[1]), 32'h5555);
    req(0, 0, 2'b00, 12'h0, 16'h0, 1, 12'h001);
    req(0, 0, 2'b00, 12'h0, 16'h0, 1, 12'h002);
    chk("oreg_lat_qv", 32'(bqv_w[1]), 32'd0);
    req(0, 0, 2'b00, 12'h0, 16'h0, 1, 12'h003);
    chk("oreg_1", {15'd0, bqv_w[1], bq_w[1]}, 32'h1_0001);
    idle(); chk("oreg_2", {15'd0, bqv_w[1], bq_w[1]}, 32'h1_0002);
    idle(); chk("oreg_3", {15'd0, bqv_w[1], bq_w[1]}, 32'h1_0003);
    idle(); chk("oreg_end", 32'(bqv_w[1]), 32'd0);
    req(1, 1, 2'b11, 12'd3500, 16'h1234, 1, 12'd3500);
    idle(); chk("oor_d0_b", 32'(bq_w[0]), 32'h0DAC);
    idle(); chk("oor_d1_b", {15'd0, bqv_w[1], bq_w[1]}, 32'h1_0000);
    req(1, 0, 2'b00, 12'd3500, 16'h0, 0, 12'h0);
    idle(); chk("oor_d0_a", 32'(aq_w[0]), 32'h1234);
    idle(); chk("oor_d1_a", {15'd0, aqv_w[1], aq_w[1]}, 32'h1_0000);
    req(1, 0, 2'b00, 12'h006, 16'h0, 1, 12'h005);
    pulse_rst("rst_ready");
    for (int k = 0; k < 100; k++) begin
      rnd(1'b0);
      @(negedge clk);
    end
    pulse_rst("rst_init");
    count_init("refill");
    req(1, 0, 2'b00, 12'h010, 16'h0, 0, 12'h0);
    idle(); chk("refill_d0", 32'(aq_w[0]), 32'h0010);
    idle(); chk("refill_d1", 32'(aq_w[1]), 32'h0010);
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      rnd(1'b0);
    end
    idle(); idle(); idle();
    run = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
